// File: rtl/lms_adapt_ctrl.sv
// Adaptation controller for the LMS equalizer: sequences IDLE/ACQ/TRACK/HOLD,
// drives update enable, step size and coefficient re-init, and judges lock from windowed |error|.
module lms_adapt_ctrl #(
    parameter logic signed [7:0] MU_ACQ   = 8'sd32,
    parameter logic signed [7:0] MU_TRK   = 8'sd4,
    parameter int                ACQ_LEN  = 1024,
    parameter int                WIN_LOG2 = 6,
    parameter logic [7:0]        LOCK_TH  = 8'd16,
    parameter logic [7:0]        LOSS_TH  = 8'd40
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic              i_start,
    input  logic              i_freeze,
    input  logic signed [7:0] i_error,
    output logic              o_lms_en,
    output logic              o_lms_rst,
    output logic signed [7:0] o_mu,
    output logic [1:0]        o_state,
    output logic              o_locked,
    output logic [7:0]        o_err_avg
);

    localparam int ACC_W = 8 + WIN_LOG2;
    localparam int CNT_W = $clog2(ACQ_LEN + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, TRACK = 2'd2, HOLD = 2'd3} state_t;

    state_t              state, state_nxt;
    state_t              prev, prev_nxt;
    logic [CNT_W-1:0]    sym_cnt, sym_cnt_nxt;
    logic [WIN_LOG2-1:0] win_cnt, win_cnt_nxt;
    logic [ACC_W-1:0]    acc, acc_nxt, acc_sum;
    logic [7:0]          err_avg_nxt, avg_new;
    logic                lms_rst_nxt, lms_en_nxt;
    logic                counted, win_end, adapting;

    // -128 maps to 128: the two's-complement negate is read back as unsigned.
    function automatic logic [7:0] abs_err(input logic signed [7:0] e);
        logic signed [7:0] n;
        n = -e;
        return e[7] ? $unsigned(n) : $unsigned(e);
    endfunction

    function automatic logic [7:0] sat_avg(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] s;
        s = a >> WIN_LOG2;
        return (|s[ACC_W-1:8]) ? 8'hFF : s[7:0];
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            prev      <= IDLE;
            sym_cnt   <= '0;
            win_cnt   <= '0;
            acc       <= '0;
            o_err_avg <= '0;
            o_lms_rst <= 1'b0;
            o_lms_en  <= 1'b0;
        end else begin
            state     <= state_nxt;
            prev      <= prev_nxt;
            sym_cnt   <= sym_cnt_nxt;
            win_cnt   <= win_cnt_nxt;
            acc       <= acc_nxt;
            o_err_avg <= err_avg_nxt;
            o_lms_rst <= lms_rst_nxt;
            o_lms_en  <= lms_en_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        prev_nxt    = prev;
        sym_cnt_nxt = sym_cnt;
        win_cnt_nxt = win_cnt;
        acc_nxt     = acc;
        err_avg_nxt = o_err_avg;
        lms_rst_nxt = 1'b0;
        adapting    = (state == ACQ) || (state == TRACK);
        // A symbol counts only when no higher-priority event claims the cycle.
        counted     = i_valid && !i_start && !i_freeze && adapting;
        lms_en_nxt  = counted;
        acc_sum     = acc + ACC_W'(abs_err(i_error));
        win_end     = counted && (win_cnt == '1);
        avg_new     = sat_avg(acc_sum);

        if (i_start) begin
            state_nxt   = ACQ;
            prev_nxt    = IDLE;
            lms_rst_nxt = 1'b1;
            sym_cnt_nxt = '0;
            win_cnt_nxt = '0;
            acc_nxt     = '0;
        end else if (i_freeze && adapting) begin
            state_nxt = HOLD;
            prev_nxt  = state;
        end else if (state == HOLD) begin
            if (!i_freeze) state_nxt = prev;
        end else if (counted) begin
            win_cnt_nxt = win_cnt + 1'b1;
            acc_nxt     = win_end ? '0 : acc_sum;
            if (state == ACQ && sym_cnt != CNT_W'(ACQ_LEN)) sym_cnt_nxt = sym_cnt + 1'b1;
            if (win_end) begin
                err_avg_nxt = avg_new;
                if (state == ACQ && sym_cnt_nxt == CNT_W'(ACQ_LEN) && avg_new < LOCK_TH) begin
                    state_nxt = TRACK;
                end else if (state == TRACK && avg_new > LOSS_TH) begin
                    state_nxt   = ACQ;
                    lms_rst_nxt = 1'b1;
                    sym_cnt_nxt = '0;
                end
            end
        end
    end

    // HOLD presents the step size and lock flag of the state it suspended.
    always_comb begin
        o_state  = state;
        o_mu     = 8'sd0;
        o_locked = 1'b0;
        case (state)
            ACQ:   o_mu = MU_ACQ;
            TRACK: begin
                o_mu     = MU_TRK;
                o_locked = 1'b1;
            end
            HOLD:  begin
                o_mu     = (prev == TRACK) ? MU_TRK : MU_ACQ;
                o_locked = (prev == TRACK);
            end
            default: o_mu = 8'sd0;
        endcase
    end

endmodule

// File: tb/tb_lms_adapt_ctrl.sv
// Randomised scoreboard bench for lms_adapt_ctrl against a queue-based reference model.
module tb_lms_adapt_ctrl;

    localparam int ACQ_LEN = 1024;
    localparam int WIN     = 64;
    localparam int LOCK_TH = 16;
    localparam int LOSS_TH = 40;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_valid = 1'b0;
    logic              i_start = 1'b0;
    logic              i_freeze = 1'b0;
    logic signed [7:0] i_error = 8'sd0;
    logic              o_lms_en;
    logic              o_lms_rst;
    logic signed [7:0] o_mu;
    logic [1:0]        o_state;
    logic              o_locked;
    logic [7:0]        o_err_avg;

    lms_adapt_ctrl dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .i_start  (i_start),
        .i_freeze (i_freeze),
        .i_error  (i_error),
        .o_lms_en (o_lms_en),
        .o_lms_rst(o_lms_rst),
        .o_mu     (o_mu),
        .o_state  (o_state),
        .o_locked (o_locked),
        .o_err_avg(o_err_avg)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int st;
        int mu;
        int lk;
        int en;
        int lr;
        int avg;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: symbol-level view of the controller.
    int m_st = 0, m_prev = 0, m_syms = 0, m_avg = 0;
    int m_win[$];

    task automatic chk(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model(input logic r, input logic v, input logic s, input logic f,
                         input logic signed [7:0] e);
        exp_t x;
        int a, sum, lr, en;
        lr = 0;
        en = 0;
        if (r) begin
            m_st = 0; m_prev = 0; m_syms = 0; m_avg = 0;
            m_win.delete();
        end else if (s) begin
            m_st = 1; m_prev = 0; lr = 1; m_syms = 0;
            m_win.delete();
        end else if (f && (m_st == 1 || m_st == 2)) begin
            m_prev = m_st;
            m_st   = 3;
        end else if (m_st == 3) begin
            if (!f) m_st = m_prev;
        end else if (v && (m_st == 1 || m_st == 2)) begin
            en = 1;
            a  = int'(e);
            if (a < 0) a = -a;
            m_win.push_back(a);
            if (m_st == 1 && m_syms < ACQ_LEN) m_syms++;
            if (m_win.size() == WIN) begin
                sum = 0;
                foreach (m_win[k]) sum += m_win[k];
                m_avg = sum / WIN;
                if (m_avg > 255) m_avg = 255;
                m_win.delete();
                if (m_st == 1 && m_syms == ACQ_LEN && m_avg < LOCK_TH) begin
                    m_st = 2;
                end else if (m_st == 2 && m_avg > LOSS_TH) begin
                    m_st = 1; lr = 1; m_syms = 0;
                end
            end
        end
        x.st  = m_st;
        x.lk  = (m_st == 2 || (m_st == 3 && m_prev == 2)) ? 1 : 0;
        x.mu  = (m_st == 1 || (m_st == 3 && m_prev == 1)) ? 32 :
                (m_st == 2 || (m_st == 3 && m_prev == 2)) ? 4 : 0;
        x.en  = en;
        x.lr  = lr;
        x.avg = m_avg;
        exp_q.push_back(x);
    endtask

    // Drives one cycle; returns at the following negedge with DUT outputs settled.
    task automatic step(input logic r, input logic v, input logic s, input logic f,
                        input logic signed [7:0] e);
        #1;
        i_rst = r; i_valid = v; i_start = s; i_freeze = f; i_error = e;
        model(r, v, s, f, e);
        @(negedge i_clk);
    endtask

    function automatic logic signed [7:0] gen_err(input int kind, input int idx);
        int m;
        case (kind)
            0: m = (idx % 2 == 0) ? 8 : -8;
            1: m = ($urandom_range(1) == 1) ? 30 : -30;
            2: m = ($urandom_range(1) == 1) ? 64 : -64;
            3: begin
                m = int'($urandom_range(10));
                if ($urandom_range(1) == 1) m = -m;
            end
            default: m = -128;
        endcase
        return 8'(m);
    endfunction

    task automatic send_valids(input int n, input int kind);
        int sent;
        logic v;
        sent = 0;
        for (int c = 0; c < n * 8 && sent < n; c++) begin
            v = ($urandom_range(3) != 0);
            step(1'b0, v, 1'b0, 1'b0, v ? gen_err(kind, sent) : 8'(int'($urandom_range(255))));
            if (v) sent++;
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge i_clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("state",   int'(o_state),   x.st);
                chk("mu",      int'(o_mu),      x.mu);
                chk("locked",  int'(o_locked),  x.lk);
                chk("lms_en",  int'(o_lms_en),  x.en);
                chk("lms_rst", int'(o_lms_rst), x.lr);
                chk("err_avg", int'(o_err_avg), x.avg);
            end
        end
    end

    initial begin : driver
        logic frz;
        @(negedge i_clk);
        for (int c = 0; c < 3; c++) step(1'b1, 1'($urandom_range(1)), 1'b0, 1'b0, 8'sd50);

        for (int c = 0; c < 20; c++) step(1'b0, 1'b1, 1'b0, 1'($urandom_range(1)), 8'sd50);
        chk("idle_state", int'(o_state), 0);
        chk("idle_avg", int'(o_err_avg), 0);

        step(1'b0, 1'b0, 1'b1, 1'b0, 8'sd0);
        chk("start_rst", int'(o_lms_rst), 1);
        chk("start_mu", int'(o_mu), 32);
        send_valids(ACQ_LEN, 0);
        chk("lock_state", int'(o_state), 2);
        chk("lock_avg", int'(o_err_avg), 8);
        chk("lock_mu", int'(o_mu), 4);
        chk("lock_locked", int'(o_locked), 1);

        send_valids(WIN, 2);
        chk("loss_state", int'(o_state), 1);
        chk("loss_avg", int'(o_err_avg), 64);
        chk("loss_rst", int'(o_lms_rst), 1);
        chk("loss_locked", int'(o_locked), 0);

        send_valids(1100, 1);
        chk("nolock_state", int'(o_state), 1);
        chk("nolock_avg", int'(o_err_avg), 30);

        step(1'b0, 1'b0, 1'b1, 1'b0, 8'sd0);
        send_valids(WIN, 4);
        chk("neg128_avg", int'(o_err_avg), 128);

        send_valids(ACQ_LEN, 3);
        chk("relock_state", int'(o_state), 2);

        send_valids(20, 3);
        for (int c = 0; c < 100; c++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, gen_err(3, c));
            if (c == 0) begin
                chk("hold_state", int'(o_state), 3);
                chk("hold_mu", int'(o_mu), 4);
                chk("hold_locked", int'(o_locked), 1);
                chk("hold_en", int'(o_lms_en), 0);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'sd0);
        chk("release_state", int'(o_state), 2);
        send_valids(64, 3);

        step(1'b0, 1'b1, 1'b1, 1'b1, 8'sd0);
        chk("sf_state", int'(o_state), 1);
        chk("sf_rst", int'(o_lms_rst), 1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'sd0);
        chk("sf_hold", int'(o_state), 3);
        chk("sf_hold_mu", int'(o_mu), 32);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'sd0);

        frz = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(39) == 0) frz = ~frz;
            step(1'($urandom_range(999) == 0), 1'($urandom_range(3) != 0),
                 1'($urandom_range(1499) == 0), frz,
                 ($urandom_range(9) == 0) ? 8'(int'($urandom_range(255))) : gen_err(3, c));
        end
        for (int c = 0; c < 5; c++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'sd0);

        @(negedge i_clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
